uart_rx: RTL
============

# uart_rx

UART receiver, the receive-side counterpart of `uart_tx`, with the same clock and baud parameters. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the asynchronous `uart_rxd` line. It presents each received byte with a one-cycle `rx_done` strobe and flags bad stop bits. It sits between the board RX pin and the user logic that consumes bytes. In the loopback bench it is driven directly by `uart_tx`.

## Interface

- `CLK_F`, 50_000_000, system clock frequency in Hz
- `UART_BPS`, 115200, baud rate
- `CLK_GOAL`, CLK_F / UART_BPS (434 at defaults), clock cycles per bit (integer division)

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `uart_rxd`  in  1  serial line; asynchronous; idle high
- `uart_data_out`  out  8  last correctly framed byte; held until the next good frame
- `rx_done`  out  1  one-cycle pulse when `uart_data_out` updates
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low
- `rx_busy`  out  1  high whenever the FSM is not in IDLE

## Operation

- **Synchronizer:** `uart_rxd` passes through two flops `s1` and `s2`, plus a history flop `s3`. All three reset to 1. Only `s2` is used internally.
- **Falling-edge detect:** `s3 == 1 && s2 == 0`.
- **Bit timer:** `baud_cnt`, width `$clog2(CLK_GOAL)`, counts 0..CLK_GOAL-1 within each bit.
  - The sample point is `baud_cnt == CLK_GOAL/2` (217 at defaults).
  - At CLK_GOAL-1 the counter wraps to 0 and the bit ends.
- **Bit index:** `bit_idx` is 3 bits, 0..7.

**FSM states:**

- **IDLE:** `baud_cnt = 0`. On falling edge, go to START.
- **START:**
  - At the sample point, if `s2 == 1` (glitch / false start), go to IDLE. No outputs change.
  - At bit end, go to DATA with `bit_idx = 0`.
- **DATA:**
  - At the sample point, `shift[bit_idx] <= s2` (LSB first).
  - At bit end, if `bit_idx == 7` go to STOP, else increment `bit_idx`.
- **STOP:** at the sample point:
  - If `s2 == 1`: `uart_data_out <= shift` and pulse `rx_done`.
  - Otherwise pulse `frame_err` and leave `uart_data_out` unchanged.
  - In both cases go to IDLE on the same edge; the second half of the stop bit is not waited for. This allows back-to-back frames with zero idle time.

**Other rules:**

- `rx_done` and `frame_err` are never high in the same cycle. Each is high for exactly one clock per frame.
- A falling edge seen while not in IDLE is ignored; it is only acted on from IDLE.
- **Reset:** while `rst_n == 0`, synchronously:
  - `state = IDLE`; `baud_cnt`, `bit_idx`, `shift` = 0
  - `uart_data_out = 8'h00`
  - `rx_done`, `frame_err`, `rx_busy` = 0
  - `s1`, `s2`, `s3` = 1
- **Reset mid-frame:** reset aborts the frame with no strobe. After release, reception resumes only on the next falling edge seen from IDLE. If the line is already low at release, no edge is detected until it returns high and falls again.

## Timing

- **Edge detect latency:** a falling edge on `uart_rxd` reaches `s2` 2 clocks later. START is entered on the following clock (3 clocks total).
- **Sampling positions:**
  - Start bit sampled at START entry + CLK_GOAL/2.
  - Data bit n sampled at START entry + (n+1)·CLK_GOAL + CLK_GOAL/2.
  - Stop bit sampled at START entry + 9·CLK_GOAL + CLK_GOAL/2.
- **Strobe timing:** `rx_done` / `frame_err` is high in the cycle after the stop sample edge.
  - That is 9·434 + 217 + 4 = 4127 clocks (82.54 µs) after the start-bit falling edge.
  - Bench tolerance: ±2 clocks.
- **`rx_busy`:** rises 3 clocks after the falling edge and falls in the same cycle `rx_done` / `frame_err` rises.
- **Baud tolerance:** with mid-bit sampling, ±2% transmitter baud mismatch must still yield correct data.
- **Output stability:** `uart_data_out` is stable from the `rx_done` cycle until the next `rx_done`.

## Test plan

- **Single byte:** reset for 20 ns, then `uart_tx` loopback sends 8'hAC.
  - `rx_done` pulses once, ~82.5 µs after the start edge.
  - `uart_data_out == 8'hAC`; `frame_err` stays 0.
- **Back-to-back:** 8'h6E then 8'hC2, second start bit immediately after the first stop bit (no idle gap).
  - Two `rx_done` pulses 4340 ± 2 clocks apart.
  - Data 8'h6E then 8'hC2.
- **Glitch:** drive `uart_rxd` low for 2000 ns (100 clocks), then high.
  - `rx_busy` is high for about 217 clocks, then returns to 0.
  - No `rx_done`, no `frame_err`; `uart_data_out` unchanged.
- **Frame error:** hand-drive the frame for 8'h55 with the stop bit low.
  - `frame_err` pulses for one clock; `rx_done` stays 0.
  - `uart_data_out` keeps the previous value (8'hC2).
  - A following good 8'h3C frame is received correctly.
- **Reset mid-frame:** assert `rst_n = 0` for 2 clocks during data bit 4.
  - All outputs are 0 next clock; no strobe for the aborted frame.
  - The next full frame 8'hA5 is received correctly.
- **Baud skew:** transmit 8'hF0 at CLK_GOAL = 425 (−2%) and at 443 (+2%).
  - Both received as 8'hF0 with no `frame_err`.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Function : 8N1 UART receiver with mid-bit sampling, glitch rejection and
//            stop-bit framing check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_F    = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CLK_GOAL = CLK_F / UART_BPS;
    localparam int c_cnt_w  = $clog2(CLK_GOAL);

    localparam logic [c_cnt_w-1:0] c_sample = c_cnt_w'(CLK_GOAL / 2);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(CLK_GOAL - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic               r_s1, r_s2, r_s3;
    logic [1:0]         r_settle;
    logic [1:0]         r_state, w_next_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_done, r_ferr;
    logic               w_fall, w_sample, w_bit_end, w_capture, w_stop_sample;

    // Edge detection is held off until s2/s3 both carry real line samples,
    // so a line that is already low when reset releases is not taken as a start.
    assign w_fall    = r_s3 & ~r_s2 & (r_settle == 2'd3);
    assign w_sample  = (r_baud_cnt == c_sample);
    assign w_bit_end = (r_baud_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_s3     <= 1'b1;
            r_settle <= 2'd0;
        end else begin
            r_s1 <= uart_rxd;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_fall) w_next_state = c_start;
            c_start: begin
                if (w_sample && r_s2) w_next_state = c_idle;
                else if (w_bit_end)   w_next_state = c_data;
            end
            c_data:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = c_stop;
            c_stop:  if (w_sample) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        rx_busy       = (r_state != c_idle);
        w_capture     = (r_state == c_data) && w_sample;
        w_stop_sample = (r_state == c_stop) && w_sample;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            if ((r_state == c_idle) || (w_next_state == c_idle) || w_bit_end)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + c_one;
            if ((r_state == c_start) && w_bit_end)
                r_bit_idx <= 3'd0;
            else if ((r_state == c_data) && w_bit_end && (r_bit_idx != 3'd7))
                r_bit_idx <= r_bit_idx + 3'd1;
            if (w_capture) r_shift[r_bit_idx] <= r_s2;
            // Leave at mid stop bit so a zero-gap next start edge is caught.
            if (w_stop_sample) begin
                if (r_s2) begin
                    r_data <= r_shift;
                    r_done <= 1'b1;
                end else begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    assign uart_data_out = r_data;
    assign rx_done       = r_done;
    assign frame_err     = r_ferr;

endmodule
`default_nettype wire
